systolic_seq_ctrl: RTL and testbench

Sequencer for the NxN systolic matrix-multiply array in `user_proj_systollic`.
- On a start command it runs one tile: clears the PE accumulators, then drives the skewed row/column feed enables for a K-deep inner product, waits for the pipeline to flush, and drains result rows over a valid/ready handshake.
- Sits between the Wishbone register file, which supplies `start`/`k_len`, and the array plus its operand buffers.

---
 rtl/systolic_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl -- tile sequencer for the NxN systolic matrix-multiply array.
//
// One tile runs as follows: clear the PE accumulators, feed the skewed row and
// column operand enables over K+N-1 steps, let the pipeline flush, then hand
// out the N result rows over a valid/ready handshake.
//
// Ports
//   wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//   start, k_len        : tile start (taken only when idle) and inner length K
//   abort               : cancel the running tile, return to idle
//   busy, done          : not-idle flag, one-cycle completion pulse
//   acc_clr             : accumulator clear to all PEs
//   feed_k              : feed step t (operand-buffer base address)
//   row_en, col_en      : per-lane operand valid, lane i active for i <= t < i+K
//   res_valid, res_row  : result row handshake (held until res_ready)
//   res_ready           : consumer accepts the offered row
//   irq, irq_ack        : sticky completion interrupt and its clear
//
// Optional feature macro: SYS_CTRL_IRQ_EN. When undefined, irq is tied low and
// irq_ack is ignored.
module systolic_seq_ctrl #(
   parameter int N      = 4,
   parameter int KW     = 8,
   parameter int PE_LAT = 1
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   input  logic                 start,
   input  logic [KW-1:0]        k_len,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 acc_clr,
   output logic [KW-1:0]        feed_k,
   output logic [N-1:0]         row_en,
   output logic [N-1:0]         col_en,
   output logic                 res_valid,
   output logic [$clog2(N)-1:0] res_row,
   input  logic                 res_ready,
   output logic                 irq,
   input  logic                 irq_ack
);
   localparam int RW = $clog2(N);
   localparam int CW = $clog2(N + PE_LAT) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
   } state_t;

   state_t        state_reg;
   logic [KW-1:0] k_reg;
   logic [KW:0]   t_reg;      // one bit wider than K so t never wraps at K = 2^KW-1
   logic [CW-1:0] flush_reg;

   logic          kill;
   logic [KW:0]   t_next;
   logic          t_last;
   logic [N-1:0]  en_next;

   assign kill   = abort && (state_reg != S_IDLE);
   assign t_next = (state_reg == S_CLEAR) ? '0 : t_reg + 1'b1;
   assign t_last = (t_reg == ({1'b0, k_reg} + (KW+1)'(N-2)));

   // Lane gi is active while 0 <= t-gi < K; a negative difference shows up
   // as the top bit of the widened subtraction.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         logic [KW+1:0] diff;
         assign diff        = {1'b0, t_next} - (KW+2)'(gi);
         assign en_next[gi] = !diff[KW+1] && (diff < {2'b00, k_reg});
      end
   endgenerate

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_reg <= S_IDLE;
         k_reg     <= '0;
         t_reg     <= '0;
         flush_reg <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         acc_clr   <= 1'b0;
         feed_k    <= '0;
         row_en    <= '0;
         col_en    <= '0;
         res_valid <= 1'b0;
         res_row   <= '0;
      end else begin
         done    <= 1'b0;
         acc_clr <= 1'b0;
         if (kill) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
            feed_k    <= '0;
            row_en    <= '0;
            col_en    <= '0;
            res_valid <= 1'b0;
            res_row   <= '0;
         end else begin
            case (state_reg)
               S_IDLE: begin
                  if (start) begin
                     state_reg <= S_CLEAR;
                     busy      <= 1'b1;
                     acc_clr   <= 1'b1;
                     k_reg     <= k_len;
                  end
               end
               S_CLEAR: begin
                  if (k_reg == '0) begin
                     state_reg <= S_DONE;
                     done      <= 1'b1;
                  end else begin
                     state_reg <= S_FEED;
                     t_reg     <= t_next;
                     feed_k    <= t_next[KW-1:0];
                     row_en    <= en_next;
                     col_en    <= en_next;
                  end
               end
               S_FEED: begin
                  if (t_last) begin
                     state_reg <= S_FLUSH;
                     flush_reg <= CW'(N - 2 + PE_LAT);
                     feed_k    <= '0;
                     row_en    <= '0;
                     col_en    <= '0;
                  end else begin
                     t_reg  <= t_next;
                     feed_k <= t_next[KW-1:0];
                     row_en <= en_next;
                     col_en <= en_next;
                  end
               end
               S_FLUSH: begin
                  if (flush_reg == '0) begin
                     state_reg <= S_DRAIN;
                     res_valid <= 1'b1;
                     res_row   <= '0;
                  end else begin
                     flush_reg <= flush_reg - 1'b1;
                  end
               end
               S_DRAIN: begin
                  if (res_ready) begin
                     if (res_row == RW'(N-1)) begin
                        state_reg <= S_DONE;
                        res_valid <= 1'b0;
                        res_row   <= '0;
                        done      <= 1'b1;
                     end else begin
                        res_row <= res_row + 1'b1;
                     end
                  end
               end
               S_DONE: begin
                  state_reg <= S_IDLE;
                  busy      <= 1'b0;
               end
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

`ifdef SYS_CTRL_IRQ_EN
   logic enter_done;
   assign enter_done = !kill &&
      (((state_reg == S_CLEAR) && (k_reg == '0)) ||
       ((state_reg == S_DRAIN) && res_ready && (res_row == RW'(N-1))));

   // Held through the DONE cycle as well, so an ack coinciding with completion
   // never swallows the interrupt.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni)
         irq <= 1'b0;
      else
         irq <= enter_done || (state_reg == S_DONE) || (irq && !irq_ack);
   end
`else
   logic unused_irq_ack;
   assign unused_irq_ack = irq_ack;
   assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: a phase-offset model of one tile (cycles since
// start, rows accepted) is compared with the DUT every cycle, and directed
// tiles pin the model with hand-computed cycle numbers from the tile timing.
module tb_systolic_seq_ctrl;
   localparam int N = 4, KW = 8, PE_LAT = 1, CAP = 320;
`ifdef SYS_CTRL_IRQ_EN
   localparam int IRQ_ON = 1;
`else
   localparam int IRQ_ON = 0;
`endif

   logic clk = 0, rst_n = 0, start = 0, abort = 0, res_ready = 1, irq_ack = 0;
   logic [KW-1:0] k_len = '0;
   logic busy, done, acc_clr, res_valid, irq;
   logic [KW-1:0] feed_k;
   logic [N-1:0] row_en, col_en;
   logic [1:0] res_row;

   always #5 clk = ~clk;

   systolic_seq_ctrl #(.N(N), .KW(KW), .PE_LAT(PE_LAT)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .start(start), .k_len(k_len),
      .abort(abort), .busy(busy), .done(done), .acc_clr(acc_clr),
      .feed_k(feed_k), .row_en(row_en), .col_en(col_en),
      .res_valid(res_valid), .res_row(res_row), .res_ready(res_ready),
      .irq(irq), .irq_ack(irq_ack));

   int n_chk = 0, n_pass = 0;
   int cyc = 0, s_cyc = 0, done_rel = -1, end_rel = 0;
   int cap_en[CAP], cap_col[CAP], cap_feed[CAP], cap_row[CAP], cap_val[CAP], cap_clr[CAP];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Model: m_d = cycles since start (1 = clear), frozen once the drain phase
   // is reached; m_row = rows accepted; m_indone marks the completion cycle.
   bit m_act = 0, m_indone = 0, m_irq = 0;
   int m_k = 0, m_d = 0, m_row = 0;
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_act = 0; m_indone = 0; m_irq = 0; m_k = 0; m_d = 0; m_row = 0;
      end else begin
         bit enter, was_done;
         enter = 0;
         was_done = m_indone;
         if (!m_act) begin
            if (start) begin m_act = 1; m_k = k_len; m_d = 1; m_row = 0; end
         end else if (m_indone) begin
            m_act = 0; m_indone = 0;
         end else if (abort) begin
            m_act = 0;
         end else if (m_d == 1 && m_k == 0) begin
            enter = 1;
         end else if (m_d < m_k + 2*N + PE_LAT) begin
            m_d++;
         end else if (res_ready) begin
            if (m_row == N-1) enter = 1;
            else m_row++;
         end
         m_irq = (IRQ_ON != 0) && (enter || was_done || (m_irq && !irq_ack));
         if (enter) m_indone = 1;
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         int t, e_en, rel;
         bit in_feed, in_drain;
         t = m_d - 2;
         in_feed  = m_act && !m_indone && m_k > 0 && m_d >= 2 && m_d <= m_k + N;
         in_drain = m_act && !m_indone && m_k > 0 && m_d == m_k + 2*N + PE_LAT;
         e_en = 0;
         if (in_feed)
            for (int i = 0; i < N; i++)
               if (t >= i && t < i + m_k) e_en |= (1 << i);
         chk("busy", busy, m_act);
         chk("done", done, m_indone);
         chk("acc_clr", acc_clr, m_act && !m_indone && m_d == 1);
         chk("row_en", row_en, e_en);
         chk("col_en", col_en, e_en);
         chk("res_valid", res_valid, in_drain);
         if (in_drain) chk("res_row", res_row, m_row);
         if (in_feed) chk("feed_k", feed_k, t % (1 << KW));
         chk("irq", irq, m_irq);
         rel = cyc - s_cyc;
         if (rel >= 0 && rel < CAP) begin
            cap_en[rel] = row_en; cap_col[rel] = col_en; cap_feed[rel] = feed_k;
            cap_row[rel] = res_row; cap_val[rel] = res_valid; cap_clr[rel] = acc_clr;
         end
         if (done) done_rel = rel;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);     chk({tag, "_done"}, done, 0);
      chk({tag, "_clr"}, acc_clr, 0);   chk({tag, "_row_en"}, row_en, 0);
      chk({tag, "_col_en"}, col_en, 0); chk({tag, "_valid"}, res_valid, 0);
      chk({tag, "_row"}, res_row, 0);   chk({tag, "_feed"}, feed_k, 0);
      chk({tag, "_irq"}, irq, 0);
   endtask

   // Starts a tile in the current cycle and returns in the first idle cycle.
   task automatic run_tile(input int k, input int bp_from, input int bp_len,
                           input int abort_at, input bit junk, input int ack_at,
                           input int rst_at);
      int rel;
      bit ok;
      ok = 0;
      s_cyc = cyc; done_rel = -1; rel = 0;
      for (int i = 0; i < CAP; i++) begin
         cap_en[i] = 0; cap_col[i] = 0; cap_feed[i] = 0;
         cap_row[i] = 0; cap_val[i] = 0; cap_clr[i] = 0;
      end
      start = 1; k_len = KW'(k); abort = (abort_at == 0);
      irq_ack = (ack_at == 0); res_ready = 1;
      for (int n = 0; n < 600; n++) begin
         tick();
         rel = cyc - s_cyc;
         start = junk && (rel == 3 || rel == 5);
         if (junk) k_len = KW'(k) ^ 8'h5A;
         abort = (rel == abort_at);
         irq_ack = (rel == ack_at);
         res_ready = !(rel >= bp_from && rel < bp_from + bp_len);
         if (rel == rst_at) begin
            rst_n = 0;
            #1;
            chk_all_zero("rst_mid_drain");
         end
         if (!busy) begin ok = 1; break; end
      end
      if (!ok) chk("tile_timeout", 0, 1);
      end_rel = rel;
      start = 0; abort = 0; irq_ack = 0; res_ready = 1;
      $display("tile k=%0d start_cycle=%0d done_rel=%0d idle_rel=%0d irq=%0d",
               k, s_cyc, done_rel, end_rel, irq);
   endtask

   task automatic ack_irq();
      irq_ack = 1;
      tick();
      irq_ack = 0;
      chk("irq_after_ack", irq, 0);
   endtask

   initial begin
      int en_tab[7];
      int s;
      en_tab = '{1, 3, 7, 15, 14, 12, 8};
      #3;
      chk_all_zero("reset");
      tick(); tick();
      rst_n = 1;
      tick();

      // Basic K=4 tile.
      run_tile(4, 1000, 0, -1, 0, -1, -1);
      for (int r = 0; r < 7; r++) begin
         chk("pin_row_en", cap_en[r+2], en_tab[r]);
         chk("pin_col_en", cap_col[r+2], en_tab[r]);
         chk("pin_feed_k", cap_feed[r+2], r);
      end
      chk("pin_flush_en", cap_en[9], 0);
      chk("pin_clr", cap_clr[1], 1);
      for (int r = 0; r < 4; r++) begin
         chk("pin_res_valid", cap_val[13+r], 1);
         chk("pin_res_row", cap_row[13+r], r);
      end
      chk("pin_done", done_rel, 17);
      chk("pin_idle", end_rel, 18);
      chk("pin_irq", irq, IRQ_ON);
      ack_irq();

      // K = 0.
      run_tile(0, 1000, 0, -1, 0, -1, -1);
      chk("k0_clr", cap_clr[1], 1);
      chk("k0_done", done_rel, 2);
      s = 0;
      for (int r = 0; r < 4; r++) s += cap_en[r] + cap_col[r] + cap_val[r];
      chk("k0_no_enables", s, 0);

      // Backpressure on row 2 for three cycles.
      run_tile(4, 15, 3, -1, 0, -1, -1);
      for (int r = 15; r < 18; r++) begin
         chk("bp_hold_valid", cap_val[r], 1);
         chk("bp_hold_row", cap_row[r], 2);
      end
      chk("bp_done", done_rel, 20);
      ack_irq();

      // Abort in FEED, then a K=2 tile started in the first idle cycle.
      run_tile(4, 1000, 0, 5, 0, -1, -1);
      chk("abort_no_done", done_rel, -1);
      chk("abort_idle", end_rel, 6);
      chk("abort_no_irq", irq, 0);
      run_tile(2, 1000, 0, -1, 0, -1, -1);
      chk("after_abort_done", done_rel, 15);

      // Start pulses and k_len changes while busy are ignored.
      run_tile(4, 1000, 0, -1, 1, -1, -1);
      chk("junk_start_done", done_rel, 17);

      // Start with abort in IDLE: start wins.
      run_tile(4, 1000, 0, 0, 0, -1, -1);
      chk("start_abort_done", done_rel, 17);

      // irq already set; ack coincident with this tile's DONE leaves it set.
      run_tile(3, 1000, 0, -1, 0, 16, -1);
      chk("ack_at_done_done", done_rel, 16);
      chk("ack_at_done_irq", irq, IRQ_ON);
      ack_irq();

      // Abort wins over a handshake in DRAIN.
      run_tile(4, 1000, 0, 14, 0, -1, -1);
      chk("drain_abort_no_done", done_rel, -1);
      chk("drain_abort_no_irq", irq, 0);

      // Largest K: the step counter must not wrap.
      run_tile(255, 1000, 0, -1, 0, -1, -1);
      chk("kmax_feed_last8", cap_feed[257], 255);
      chk("kmax_feed_wrapbits", cap_feed[258], 0);
      chk("kmax_en_last", cap_en[258], 12);
      chk("kmax_done", done_rel, 268);
      ack_irq();

      // Asynchronous reset mid-drain, then a normal tile.
      run_tile(4, 1000, 0, -1, 0, -1, 14);
      tick();
      rst_n = 1;
      tick();
      run_tile(1, 1000, 0, -1, 0, -1, -1);
      chk("post_reset_done", done_rel, 14);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
